// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) in EX.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module ex_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [1:0]      FunctE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [4:0]      RDE,
  input  logic            FlushE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output logic [4:0]      RdOutE
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t st, st_nx;

  logic [XLEN-1:0] q, rem, dvs, dvd;
  logic [CW-1:0]   cnt;
  logic            neg_a, neg_b, is_rem, dz_q, ov_q;
  logic [4:0]      rd_q;

  // Accept-time operand decode
  logic            sgn_op, na, nb, dz, ov, special, accept;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    sgn_op  = ~FunctE[0];
    na      = sgn_op & RD1E[XLEN-1];
    nb      = sgn_op & RD2E[XLEN-1];
    abs_a   = na ? -RD1E : RD1E;
    abs_b   = nb ? -RD2E : RD2E;
    dz      = (RD2E == '0);
    ov      = sgn_op & (RD1E == {1'b1, {(XLEN-1){1'b0}}})
                     & (RD2E == '1);
    special = dz | ov;
    accept  = (st == IDLE) & StartE & ~FlushE;
  end

  // One restoring shift-subtract step; rem is kept one bit wider
  // during the compare so large unsigned divisors cannot overflow.
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx, q_nx;

  always_comb begin
    rem_sh = {rem, q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = (rem_sh >= {1'b0, dvs});
    rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    q_nx   = {q[XLEN-2:0], ge};
  end

  // Sign fixup and special-case override
  function automatic logic [XLEN-1:0] fix(
    input logic [XLEN-1:0] qv,
    input logic [XLEN-1:0] rv,
    input logic [XLEN-1:0] a,
    input logic            sa,
    input logic            sb,
    input logic            rsel,
    input logic            z,
    input logic            o
  );
    logic [XLEN-1:0] r;
    unique case (1'b1)
      z:       r = rsel ? a : '1;
      o:       r = rsel ? '0 : a;
      default: r = rsel ? (sa ? -rv : rv)
                        : ((sa ^ sb) ? -qv : qv);
    endcase
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // Next-state logic
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: if (accept) begin
`ifdef DIV_EARLY_OUT_EN
        st_nx = special ? DONE : CALC;
`else
        st_nx = CALC;
`endif
      end
      CALC: if (cnt == CW'(1)) st_nx = DONE;
      DONE: st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
    if (FlushE) st_nx = IDLE;
  end

  // Output decode
  always_comb begin
    BusyE = accept | (st == CALC);
  end

  // Datapath, counter and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      rem     <= '0;
      dvs     <= '0;
      dvd     <= '0;
      cnt     <= '0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      is_rem  <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      rd_q    <= '0;
      DoneE   <= 1'b0;
      ResultE <= '0;
      RdOutE  <= '0;
    end else begin
      DoneE <= 1'b0;
      if (!FlushE) begin
        unique case (st)
          IDLE: if (StartE) begin
            q      <= abs_a;
            rem    <= '0;
            dvs    <= abs_b;
            dvd    <= RD1E;
            neg_a  <= na;
            neg_b  <= nb;
            is_rem <= FunctE[1];
            dz_q   <= dz;
            ov_q   <= ov;
            rd_q   <= RDE;
            cnt    <= CW'(XLEN);
`ifdef DIV_EARLY_OUT_EN
            if (special) begin
              DoneE   <= 1'b1;
              ResultE <= fix('0, '0, RD1E, na, nb,
                             FunctE[1], dz, ov);
              RdOutE  <= RDE;
            end
`endif
          end
          CALC: begin
            q   <= q_nx;
            rem <= rem_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              DoneE   <= 1'b1;
              ResultE <= fix(q_nx, rem_nx, dvd, neg_a,
                             neg_b, is_rem, dz_q, ov_q);
              RdOutE  <= rd_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: directed checks for ex_div_unit.
// Expected values are hand-computed constants.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE;
  logic [1:0]  FunctE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [4:0]  RDE;
  logic        FlushE;
  logic        BusyE;
  logic        DoneE;
  logic [31:0] ResultE;
  logic [4:0]  RdOutE;

  int pass = 0;
  int total = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SLAT = 1;
`else
  localparam int SLAT = 33;
`endif

  ex_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .FunctE(FunctE),
    .RD1E(RD1E), .RD2E(RD2E), .RDE(RDE), .FlushE(FlushE),
    .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE),
    .RdOutE(RdOutE)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one op from IDLE; returns result, rd, latency, busy cycles.
  task automatic do_op(
    input  logic [1:0]  f,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  rd,
    output logic [31:0] res,
    output logic [4:0]  rdo,
    output int          lat,
    output int          busy
  );
    FunctE = f; RD1E = a; RD2E = b; RDE = rd; StartE = 1'b1;
    #1;
    busy = BusyE ? 1 : 0;
    tick;
    StartE = 1'b0; RD1E = 32'hdead_beef; RD2E = 32'h0bad_f00d; RDE = 5'd31;
    lat = 1;
    while (!DoneE && lat < 100) begin
      busy += BusyE ? 1 : 0;
      tick;
      lat++;
    end
    busy += BusyE ? 1 : 0;
    res = ResultE;
    rdo = RdOutE;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; StartE = 1'b0; FunctE = 2'b00; RD1E = '0; RD2E = '0;
    RDE = '0; FlushE = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    total++; if (DoneE !== 1'b0) $display("FAIL reset_done got %b want 0", DoneE); else pass++;
    total++; if (ResultE !== 32'h0) $display("FAIL reset_result got %h want 0", ResultE); else pass++;
    total++; if (RdOutE !== 5'd0) $display("FAIL reset_rd got %0d want 0", RdOutE); else pass++;
    total++; if (BusyE !== 1'b0) $display("FAIL reset_busy got %b want 0", BusyE); else pass++;
    tick;
  endtask

  task automatic test_basic;
    logic [31:0] r; logic [4:0] d; int l, b;
    do_op(2'b00, 32'd100, 32'd7, 5'd5, r, d, l, b);
    total++; if (r !== 32'd14) $display("FAIL div100_7 got %0d want 14", r); else pass++;
    total++; if (d !== 5'd5) $display("FAIL div100_7_rd got %0d want 5", d); else pass++;
    total++; if (l !== 33) $display("FAIL div_latency got %0d want 33", l); else pass++;
    total++; if (b !== 33) $display("FAIL div_busy_cycles got %0d want 33", b); else pass++;
    total++; if (DoneE !== 1'b0) $display("FAIL done_pulse got %b want 0", DoneE); else pass++;
    total++; if (ResultE !== 32'd14) $display("FAIL result_hold got %0d want 14", ResultE); else pass++;
  endtask

  task automatic test_signs;
    logic [31:0] r; logic [4:0] d; int l, b;
    do_op(2'b10, 32'hffff_fff9, 32'd2, 5'd1, r, d, l, b);
    total++; if (r !== 32'hffff_ffff) $display("FAIL rem_m7_2 got %h want ffffffff", r); else pass++;
    do_op(2'b00, 32'hffff_fff9, 32'd2, 5'd2, r, d, l, b);
    total++; if (r !== 32'hffff_fffd) $display("FAIL div_m7_2 got %h want fffffffd", r); else pass++;
    do_op(2'b01, 32'hffff_fff9, 32'd2, 5'd3, r, d, l, b);
    total++; if (r !== 32'h7fff_fffc) $display("FAIL divu_big_2 got %h want 7ffffffc", r); else pass++;
    do_op(2'b00, 32'd7, 32'hffff_fffe, 5'd4, r, d, l, b);
    total++; if (r !== 32'hffff_fffd) $display("FAIL div_7_m2 got %h want fffffffd", r); else pass++;
    do_op(2'b10, 32'd7, 32'hffff_fffe, 5'd4, r, d, l, b);
    total++; if (r !== 32'd1) $display("FAIL rem_7_m2 got %h want 1", r); else pass++;
    do_op(2'b11, 32'hffff_fff0, 32'h8000_0001, 5'd6, r, d, l, b);
    total++; if (r !== 32'h7fff_ffef) $display("FAIL remu_large_div got %h want 7fffffef", r); else pass++;
    do_op(2'b01, 32'hffff_fff0, 32'h8000_0001, 5'd6, r, d, l, b);
    total++; if (r !== 32'd1) $display("FAIL divu_large_div got %h want 1", r); else pass++;
  endtask

  task automatic test_div_zero;
    logic [31:0] r; logic [4:0] d; int l, b;
    do_op(2'b00, 32'd5, 32'd0, 5'd8, r, d, l, b);
    total++; if (r !== 32'hffff_ffff) $display("FAIL div_5_0 got %h want ffffffff", r); else pass++;
    total++; if (l !== SLAT) $display("FAIL dz_latency got %0d want %0d", l, SLAT); else pass++;
    total++; if (b !== SLAT) $display("FAIL dz_busy got %0d want %0d", b, SLAT); else pass++;
    total++; if (d !== 5'd8) $display("FAIL dz_rd got %0d want 8", d); else pass++;
    do_op(2'b11, 32'h1234, 32'd0, 5'd9, r, d, l, b);
    total++; if (r !== 32'h1234) $display("FAIL remu_0 got %h want 1234", r); else pass++;
    do_op(2'b10, 32'hffff_fffb, 32'd0, 5'd9, r, d, l, b);
    total++; if (r !== 32'hffff_fffb) $display("FAIL rem_m5_0 got %h want fffffffb", r); else pass++;
    do_op(2'b01, 32'd5, 32'd0, 5'd9, r, d, l, b);
    total++; if (r !== 32'hffff_ffff) $display("FAIL divu_5_0 got %h want ffffffff", r); else pass++;
  endtask

  task automatic test_overflow;
    logic [31:0] r; logic [4:0] d; int l, b;
    do_op(2'b00, 32'h8000_0000, 32'hffff_ffff, 5'd10, r, d, l, b);
    total++; if (r !== 32'h8000_0000) $display("FAIL div_ovf got %h want 80000000", r); else pass++;
    total++; if (l !== SLAT) $display("FAIL ovf_latency got %0d want %0d", l, SLAT); else pass++;
    do_op(2'b10, 32'h8000_0000, 32'hffff_ffff, 5'd11, r, d, l, b);
    total++; if (r !== 32'h0) $display("FAIL rem_ovf got %h want 0", r); else pass++;
    do_op(2'b01, 32'h8000_0000, 32'hffff_ffff, 5'd12, r, d, l, b);
    total++; if (r !== 32'h0) $display("FAIL divu_ovfops got %h want 0", r); else pass++;
    total++; if (l !== 33) $display("FAIL divu_ovfops_lat got %0d want 33", l); else pass++;
    do_op(2'b11, 32'h8000_0000, 32'hffff_ffff, 5'd13, r, d, l, b);
    total++; if (r !== 32'h8000_0000) $display("FAIL remu_ovfops got %h want 80000000", r); else pass++;
  endtask

  task automatic test_flush;
    logic [31:0] r; logic [4:0] d; int l, b, seen;
    do_op(2'b01, 32'd9, 32'd2, 5'd3, r, d, l, b);
    total++; if (r !== 32'd4) $display("FAIL pre_flush got %0d want 4", r); else pass++;
    FunctE = 2'b00; RD1E = 32'd100; RD2E = 32'd7; RDE = 5'd7; StartE = 1'b1;
    tick;
    StartE = 1'b0;
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      seen += DoneE ? 1 : 0;
      tick;
    end
    FlushE = 1'b1;
    #1;
    total++; if (BusyE !== 1'b1) $display("FAIL busy_before_flush got %b want 1", BusyE); else pass++;
    tick;
    FlushE = 1'b0;
    #1;
    total++; if (BusyE !== 1'b0) $display("FAIL busy_after_flush got %b want 0", BusyE); else pass++;
    total++; if (ResultE !== 32'd4) $display("FAIL flush_result_kept got %0d want 4", ResultE); else pass++;
    total++; if (RdOutE !== 5'd3) $display("FAIL flush_rd_kept got %0d want 3", RdOutE); else pass++;
    for (int c = 11; c < 40; c++) begin
      seen += DoneE ? 1 : 0;
      if (c == 11) tick;
      else break;
    end
    do_op(2'b01, 32'd50, 32'd3, 5'd9, r, d, l, b);
    seen += 0;
    total++; if (seen !== 0) $display("FAIL flush_no_done got %0d want 0", seen); else pass++;
    total++; if (r !== 32'd16) $display("FAIL after_flush got %0d want 16", r); else pass++;
    total++; if (d !== 5'd9) $display("FAIL after_flush_rd got %0d want 9", d); else pass++;
    total++; if (l !== 33) $display("FAIL after_flush_lat got %0d want 33", l); else pass++;
  endtask

  task automatic test_rst_mid;
    int seen;
    FunctE = 2'b00; RD1E = 32'd100; RD2E = 32'd7; RDE = 5'd5; StartE = 1'b1;
    tick;
    StartE = 1'b0;
    for (int c = 0; c < 5; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    total++; if (DoneE !== 1'b0) $display("FAIL rst_mid_done got %b want 0", DoneE); else pass++;
    total++; if (ResultE !== 32'h0) $display("FAIL rst_mid_result got %h want 0", ResultE); else pass++;
    total++; if (RdOutE !== 5'd0) $display("FAIL rst_mid_rd got %0d want 0", RdOutE); else pass++;
    total++; if (BusyE !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", BusyE); else pass++;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      seen += DoneE ? 1 : 0;
      tick;
    end
    total++; if (seen !== 0) $display("FAIL rst_mid_no_done got %0d want 0", seen); else pass++;
  endtask

  task automatic test_back_to_back;
    int t, t1, t2;
    FunctE = 2'b01; RD1E = 32'd1000; RD2E = 32'd10; RDE = 5'd1; StartE = 1'b1;
    tick;
    RD1E = 32'd77; RD2E = 32'd7; RDE = 5'd2;
    t = 1;
    while (!DoneE && t < 100) begin tick; t++; end
    t1 = t;
    total++; if (t1 !== 33) $display("FAIL b2b_first_lat got %0d want 33", t1); else pass++;
    total++; if (ResultE !== 32'd100) $display("FAIL b2b_first_res got %0d want 100", ResultE); else pass++;
    total++; if (RdOutE !== 5'd1) $display("FAIL b2b_first_rd got %0d want 1", RdOutE); else pass++;
    total++; if (BusyE !== 1'b0) $display("FAIL b2b_done_busy got %b want 0", BusyE); else pass++;
    tick; t++;
    total++; if (BusyE !== 1'b1) $display("FAIL b2b_second_accept got %b want 1", BusyE); else pass++;
    while (!DoneE && t < 200) begin tick; t++; end
    StartE = 1'b0;
    t2 = t;
    total++; if (t2 - t1 !== 34) $display("FAIL b2b_gap got %0d want 34", t2 - t1); else pass++;
    total++; if (ResultE !== 32'd11) $display("FAIL b2b_second_res got %0d want 11", ResultE); else pass++;
    total++; if (RdOutE !== 5'd2) $display("FAIL b2b_second_rd got %0d want 2", RdOutE); else pass++;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_div_zero;
    test_overflow;
    test_flush;
    test_rst_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
